alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequential issue/capture stage that sits directly upstream of the combinational IEEE-754 `ALU`. It accepts operand/opcode triples over a valid/ready handshake and buffers them in a small FIFO. Each operation is driven onto the ALU inputs and held stable for a fixed settle window, then the ALU result is registered. The result is presented downstream with IEEE-754 class flags under a second valid/ready handshake.

## Interface
- `WIDTH`, 32: operand/result width; single-precision layout (1 sign, 8 exponent, 23 mantissa).
- `SETTLE`, 2: cycles the ALU inputs are held before capture; legal range 1–15.
- `DEPTH`, 2: input FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  FIFO not full.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_sel`  in  3  ALU opcode.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_sel`  out  3  registered opcode to the ALU.
- `alu_out`  in  WIDTH  combinational ALU result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  WIDTH  captured result.
- `out_flags`  out  5  {illegal, nan, inf, denorm, zero}.

## Operation
- Push on `in_valid && in_ready`. `in_ready = !full`, registered, with no combinational path from `out_ready`.
- FSM states:
  - **IDLE**: if FIFO is non-empty, pop the head, load `alu_a/alu_b/alu_sel`, load `cnt=SETTLE-1`, go to DRIVE.
  - **DRIVE**: hold `alu_*` stable. Decrement `cnt`. At `cnt==0`, capture `out_result`/`out_flags`, set `out_valid`, go to HOLD.
  - **HOLD**: keep outputs stable until `out_ready`. On handshake:
    - FIFO non-empty: pop and go directly to DRIVE (same edge).
    - Otherwise: clear `out_valid` and go to IDLE.
- Legal opcodes are 000–101 and are forwarded verbatim. Opcodes 110/111 still traverse the FSM, but `alu_sel` is driven as 000. Capture forces `out_result=0` and `out_flags=5'b10000`.
- Flags are computed from the captured result, with `e=exp`, `m=mantissa`:
  - zero: `e==0 && m==0`
  - denorm: `e==0 && m!=0`
  - inf: `e==8'hFF && m==0`
  - nan: `e==8'hFF && m!=0`
  - Sign does not affect any flag.
- FIFO pointers wrap modulo `DEPTH`, with an extra bit to distinguish full from empty.
- A push and a pop on the same edge are both honoured; occupancy is unchanged.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`
  - `out_result=0`, `out_flags=0`
  - `alu_a=alu_b=0`, `alu_sel=000`
  - FIFO empty, FSM in IDLE, `cnt=0`
- Latency: an accept at edge N into an empty, idle block pops at edge N+1. `out_valid` rises at edge N+1+SETTLE.
- Throughput with `out_ready` held high: one result per SETTLE+1 cycles.
- `alu_*` change only on a pop edge and are constant for the whole DRIVE and HOLD interval.
- `out_result` and `out_flags` are constant while `out_valid && !out_ready`.
- Reset asserted mid-operation: everything returns to the reset values immediately; FIFO contents and in-flight results are discarded.
- Back-pressure: with `out_ready` low, the FIFO fills. `in_ready` falls on the edge that makes the FIFO full and rises one edge after the pop that frees an entry.

## Structure
- Package `alu_pkg`:
  - opcode width and legal-opcode constants
  - exponent/mantissa field widths and the `EXP_MAX` constant
  - flag bit index constants
  - FSM state enum {IDLE, DRIVE, HOLD}
- Sub-module `alu_op_fifo`: parameterised synchronous FIFO with WIDTH*2+3-bit entries. The FSM, settle counter and flag classifier live in the top.
- `ALU` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then a single op `a=41400000`, `b=40800000`, `sel=101`, with a stub `alu_out=40400000` -> `out_valid` 3 cycles after accept (SETTLE=2), `out_result=40400000`, `flags=00000`.
- Stub `alu_out` set to 7F800000, 7FC00000, 00000000 and 00600000 in turn -> `flags` 00100, 01000, 00001 and 00010 respectively.
- `sel=111`, any operands -> `alu_sel=000`, `out_result=0`, `flags=10000`.
- `out_ready` held low and 3 ops offered -> 2 accepted into the FIFO plus 1 held in HOLD. `in_ready` low at the third. Releasing `out_ready` drains them in order with a 3-cycle spacing.
- `out_ready` held high and a stream of 4 ops -> results in order, one every 3 cycles, with `alu_*` stable throughout each DRIVE interval.
- `rst` pulsed during DRIVE with the FIFO holding 1 entry -> all outputs at reset values next cycle and no stale result afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and IEEE-754 single-precision classifier for the
// ALU issue/capture stage.
package alu_pkg;

  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_LAST_LEGAL = 3'b101;
  localparam logic [OP_W-1:0] OP_SAFE = 3'b000;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int unsigned FLAG_W = 5;
  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_DENORM = 1;
  localparam int unsigned FLAG_INF = 2;
  localparam int unsigned FLAG_NAN = 3;
  localparam int unsigned FLAG_ILLEGAL = 4;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StHold
  } state_e;

  function automatic logic op_is_legal(logic [OP_W-1:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

  // Sign is deliberately ignored; only exponent and mantissa select the class.
  function automatic logic [FLAG_W-1:0] classify(logic [EXP_W-1:0] e, logic [MAN_W-1:0] m);
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLAG_ZERO] = (e == '0) && (m == '0);
    f[FLAG_DENORM] = (e == '0) && (m != '0);
    f[FLAG_INF] = (e == EXP_MAX) && (m == '0);
    f[FLAG_NAN] = (e == EXP_MAX) && (m != '0);
    return f;
  endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous FIFO for pending ALU operations; pointers carry one extra wrap bit so
// full and empty are distinguishable.
module alu_op_fifo #(
  parameter int unsigned Width = 67,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             full_next_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PtrW = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wptr_d = do_push ? wptr_q + PtrW'(1) : wptr_q;
  assign rptr_d = do_pop ? rptr_q + PtrW'(1) : rptr_q;

  assign full_next_o = (wptr_d[AddrW] != rptr_d[AddrW]) &&
                       (wptr_d[AddrW-1:0] == rptr_d[AddrW-1:0]);

  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) begin
        mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue/capture stage in front of the combinational ALU: buffers operations, holds the
// ALU inputs for a settle window, then captures and classifies the result.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_a_i,
  input  logic [WIDTH-1:0]  in_b_i,
  input  logic [OP_W-1:0]   in_sel_i,
  output logic [WIDTH-1:0]  alu_a_o,
  output logic [WIDTH-1:0]  alu_b_o,
  output logic [OP_W-1:0]   alu_sel_o,
  input  logic [WIDTH-1:0]  alu_out_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_result_o,
  output logic [FLAG_W-1:0] out_flags_o
);

  localparam int unsigned EntryW = 2 * WIDTH + OP_W;
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
  logic                illegal_q, illegal_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_result_q, out_result_d;
  logic [FLAG_W-1:0]   out_flags_q, out_flags_d;
  logic                in_ready_q, in_ready_d;

  logic                push, pop;
  logic [EntryW-1:0]   head;
  logic                fifo_empty, fifo_full, fifo_full_next;
  logic [WIDTH-1:0]    head_a, head_b;
  logic [OP_W-1:0]     head_sel;

  assign push = in_valid_i && in_ready_q;

  alu_op_fifo #(
    .Width(EntryW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .wdata_i     ({in_sel_i, in_a_i, in_b_i}),
    .pop_i       (pop),
    .rdata_o     (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .full_next_o (fifo_full_next)
  );

  assign head_sel = head[EntryW-1 -: OP_W];
  assign head_a   = head[2*WIDTH-1 -: WIDTH];
  assign head_b   = head[WIDTH-1:0];

  // Ready drops on the edge that fills the FIFO but only returns one edge after it
  // stops being full, so there is no path from out_ready_i to in_ready_o.
  assign in_ready_d = !fifo_full_next && !fifo_full;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    illegal_d    = illegal_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    pop          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d = StHold;
          if (illegal_q) begin
            out_result_d = '0;
            out_flags_d = FLAG_W'(1) << FLAG_ILLEGAL;
          end else begin
            out_result_d = alu_out_i;
            out_flags_d = classify(alu_out_i[WIDTH-2 -: EXP_W], alu_out_i[MAN_W-1:0]);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StHold: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop = 1'b1;
            state_d = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      alu_a_d   = head_a;
      alu_b_d   = head_b;
      illegal_d = !op_is_legal(head_sel);
      alu_sel_d = op_is_legal(head_sel) ? head_sel : OP_SAFE;
      cnt_d     = CntLoad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= OP_SAFE;
      illegal_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      illegal_q    <= illegal_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_flags_o  = out_flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a stub ALU (fixed value or a+b of the driven
// operands).
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_sel = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  logic [31:0] stub_val = '0;
  logic        use_model = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  assign alu_out = use_model ? (alu_a + alu_b) : stub_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl #(
    .WIDTH (32),
    .SETTLE(2),
    .DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_sel_i    (in_sel),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_sel_o   (alu_sel),
    .alu_out_i   (alu_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_result_o(out_result),
    .out_flags_o (out_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [107:0] got;
    logic [107:0] want;
    tick();
    tick();
    got  = {in_ready, out_valid, out_result, out_flags, alu_a, alu_b, alu_sel};
    want = {1'b1, 1'b0, 32'h0, 5'h0, 32'h0, 32'h0, 3'b000};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_values: got %h want %h", got, want);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL after_reset: got rdy/vld %b want 10", {in_ready, out_valid});
    end
  endtask

  // One op into an idle block; valid must rise SETTLE+1 edges after the accept.
  task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel, input logic [31:0] stub,
                         input logic [31:0] exp_res, input logic [4:0] exp_flags,
                         input logic [2:0] exp_sel);
    int n;
    use_model = 1'b0;
    stub_val = stub;
    in_a = a;
    in_b = b;
    in_sel = sel;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 3) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles want 3", name, n);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_sel} !== {a, b, exp_sel}) begin
      n_err++;
      $display("FAIL %s_alu_inputs: got %h %h %b want %h %h %b", name, alu_a, alu_b,
               alu_sel, a, b, exp_sel);
    end
    n_cmp++;
    if ({out_result, out_flags} !== {exp_res, exp_flags}) begin
      n_err++;
      $display("FAIL %s_result: got %h/%b want %h/%b", name, out_result, out_flags,
               exp_res, exp_flags);
    end
    stub_val = ~stub;
    tick();
    n_cmp++;
    if ({out_valid, out_result, out_flags} !== {1'b1, exp_res, exp_flags}) begin
      n_err++;
      $display("FAIL %s_hold: got %b/%h/%b want 1/%h/%b", name, out_valid, out_result,
               out_flags, exp_res, exp_flags);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_handshake: got out_valid %b want 0", name, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r [3];
    logic        ready_seen;
    int          n;
    int          last;
    use_model = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'h3F800000 + 32'(i * 16);
      in_b = 32'h00000005 + 32'(i);
      exp_r[i] = in_a + in_b;
      in_sel = 3'b000;
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL bp_accept%0d: got in_ready %b want 1", i, in_ready);
      end
      tick();
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: got in_ready %b want 0", in_ready);
    end
    in_a = 32'hDEADBEEF;
    ready_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ready_seen |= in_ready;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (ready_seen !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stays_full: got in_ready seen %b want 0", ready_seen);
    end
    n_cmp++;
    if ({out_valid, out_result} !== {1'b1, exp_r[0]}) begin
      n_err++;
      $display("FAIL bp_first_held: got %b/%h want 1/%h", out_valid, out_result, exp_r[0]);
    end
    out_ready = 1'b1;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      n_cmp++;
      if ({out_valid, out_result} !== {1'b1, exp_r[k]}) begin
        n_err++;
        $display("FAIL bp_drain%0d: got %b/%h want 1/%h", k, out_valid, out_result, exp_r[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if (cyc - last !== 3) begin
          n_err++;
          $display("FAIL bp_spacing%0d: got %0d want 3", k, cyc - last);
        end
      end
      last = cyc;
      tick();
    end
    out_ready = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_empty_after: got rdy/vld %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    for (int i = 0; i < 4; i++) begin
      va[i] = 32'h40000000 + 32'(i * 256);
      vb[i] = 32'h00000011 * 32'(i + 1);
    end
    use_model = 1'b1;
    out_ready = 1'b1;
    fork
      begin
        logic acc;
        int   n;
        for (int i = 0; i < 4; i++) begin
          in_a = va[i];
          in_b = vb[i];
          in_sel = 3'(i);
          in_valid = 1'b1;
          n = 0;
          do begin
            acc = in_ready;
            tick();
            n++;
          end while (!acc && n < 30);
        end
        in_valid = 1'b0;
      end
      begin
        int n;
        int last;
        last = 0;
        for (int k = 0; k < 4; k++) begin
          n = 0;
          while (!out_valid && n < 40) begin
            tick();
            n++;
          end
          n_cmp++;
          if ({out_valid, out_result, out_flags} !== {1'b1, va[k] + vb[k], 5'b00000}) begin
            n_err++;
            $display("FAIL b2b_result%0d: got %b/%h/%b want 1/%h/00000", k, out_valid,
                     out_result, out_flags, va[k] + vb[k]);
          end
          n_cmp++;
          if ({alu_a, alu_b, alu_sel} !== {va[k], vb[k], 3'(k)}) begin
            n_err++;
            $display("FAIL b2b_alu_stable%0d: got %h %h %b want %h %h %b", k, alu_a, alu_b,
                     alu_sel, va[k], vb[k], 3'(k));
          end
          if (k > 0) begin
            n_cmp++;
            if (cyc - last !== 3) begin
              n_err++;
              $display("FAIL b2b_spacing%0d: got %0d want 3", k, cyc - last);
            end
          end
          last = cyc;
          tick();
        end
      end
    join
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    logic [107:0] got;
    logic [107:0] want;
    logic         stale;
    use_model = 1'b0;
    stub_val = 32'h3F800000;
    out_ready = 1'b0;
    in_sel = 3'b001;
    in_valid = 1'b1;
    in_a = 32'h11111111;
    tick();
    in_a = 32'h22222222;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    got  = {in_ready, out_valid, out_result, out_flags, alu_a, alu_b, alu_sel};
    want = {1'b1, 1'b0, 32'h0, 5'h0, 32'h0, 32'h0, 3'b000};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL midop_reset_values: got %h want %h", got, want);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      stale |= out_valid;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (stale !== 1'b0) begin
      n_err++;
      $display("FAIL midop_no_stale: got out_valid seen %b want 0", stale);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_op("single", 32'h41400000, 32'h40800000, 3'b101, 32'h40400000,
            32'h40400000, 5'b00000, 3'b101);
    test_op("inf", 32'h1, 32'h2, 3'b000, 32'h7F800000, 32'h7F800000, 5'b00100, 3'b000);
    test_op("nan", 32'h3, 32'h4, 3'b001, 32'h7FC00000, 32'h7FC00000, 5'b01000, 3'b001);
    test_op("zero", 32'h5, 32'h6, 3'b010, 32'h00000000, 32'h00000000, 5'b00001, 3'b010);
    test_op("denorm", 32'h7, 32'h8, 3'b011, 32'h00600000, 32'h00600000, 5'b00010, 3'b011);
    test_op("neg_inf", 32'h9, 32'hA, 3'b100, 32'hFF800000, 32'hFF800000, 5'b00100, 3'b100);
    test_op("illegal", 32'h3F800000, 32'h40000000, 3'b111, 32'h12345678,
            32'h00000000, 5'b10000, 3'b000);
    test_op("illegal110", 32'hAAAA5555, 32'h5555AAAA, 3'b110, 32'h7F800000,
            32'h00000000, 5'b10000, 3'b000);
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_op("recover", 32'h41400000, 32'h40800000, 3'b101, 32'h40400000,
            32'h40400000, 5'b00000, 3'b101);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
